// File: rtl/display_decoder.sv
// Read-back decoder for a multiplexed 7-segment time display. It captures stable
// digit patterns, assembles four-digit frames and reports time, blank, error and stale scan.
module display_decoder #(
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] digit_select,
   input  logic [6:0] digit_display,
   output logic [4:0] ore,
   output logic [5:0] minute,
   output logic       frame_valid,
   output logic       frame_blank,
   output logic       frame_error,
   output logic       stale
);
   localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   typedef enum logic [0:0] {COLLECT = 1'b0, CHECK = 1'b1} state_t;

   function automatic logic is_one_cold(input logic [3:0] sel);
      logic [3:0] low;
      low = ~sel;
      return (low != 4'b0000) && ((low & (low - 4'b0001)) == 4'b0000);
   endfunction

   // Result packing: {bad, blank, value}
   function automatic logic [5:0] glyph(input logic [6:0] seg);
      case (seg)
         7'h40:   glyph = {2'b00, 4'd0};
         7'h79:   glyph = {2'b00, 4'd1};
         7'h24:   glyph = {2'b00, 4'd2};
         7'h30:   glyph = {2'b00, 4'd3};
         7'h19:   glyph = {2'b00, 4'd4};
         7'h12:   glyph = {2'b00, 4'd5};
         7'h02:   glyph = {2'b00, 4'd6};
         7'h78:   glyph = {2'b00, 4'd7};
         7'h00:   glyph = {2'b00, 4'd8};
         7'h10:   glyph = {2'b00, 4'd9};
         7'h7F:   glyph = {2'b01, 4'd0};
         default: glyph = {2'b10, 4'd0};
      endcase
   endfunction

   logic [3:0]  sel_r;
   logic [6:0]  seg_r;
   logic [3:0]  stab_r;
   logic [3:0]  stab_nxt_s;
   logic        stable_s;
   logic        reach_s;
   logic        pend_r;
   logic        capture_s;
   logic [5:0]  glyph_s;
   logic [3:0]  val_r [4];
   logic [3:0]  blank_r;
   logic [3:0]  bad_r;
   logic [3:0]  seen_r;
   state_t      state_r;
   state_t      state_nxt_s;
   logic [6:0]  hours_s;
   logic [5:0]  minutes_s;
   logic        range_err_s;
   logic [15:0] stale_cnt_r;
   logic [15:0] stale_cnt_nxt_s;

   // Stability tracking: the incoming sample is compared with the registered one
   always_comb begin
      stable_s   = (digit_select == sel_r) && (digit_display == seg_r) && is_one_cold(digit_select);
      stab_nxt_s = 4'd0;
      if (!stable_s) begin
         stab_nxt_s = 4'd0;
      end else if (stab_r >= SETTLE_C) begin
         stab_nxt_s = SETTLE_C;
      end else begin
         stab_nxt_s = stab_r + 4'd1;
      end
      reach_s   = stable_s && (stab_r != SETTLE_C) && (stab_nxt_s == SETTLE_C);
      // A pattern that settled during CHECK is picked up on the following COLLECT edge
      capture_s = (state_r == COLLECT) && (reach_s || (pend_r && (stab_r == SETTLE_C)));
      glyph_s   = glyph(seg_r);
   end

   // Input registers, stability counter and deferred-capture flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_r  <= 4'hF;
         seg_r  <= 7'h7F;
         stab_r <= 4'd0;
         pend_r <= 1'b0;
      end else begin
         sel_r  <= digit_select;
         seg_r  <= digit_display;
         stab_r <= stab_nxt_s;
         pend_r <= (state_r == CHECK) && reach_s;
      end
   end

   // Slot storage; sel_r is one-cold whenever a capture happens
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) val_r[i] <= 4'd0;
         blank_r <= 4'b0000;
         bad_r   <= 4'b0000;
         seen_r  <= 4'b0000;
      end else begin
         if (capture_s) begin
            for (int i = 0; i < 4; i++) begin
               if (!sel_r[i]) begin
                  val_r[i]   <= glyph_s[3:0];
                  blank_r[i] <= glyph_s[4];
                  bad_r[i]   <= glyph_s[5];
               end
            end
         end
         if (state_r == CHECK) begin
            seen_r <= 4'b0000;
         end else if (capture_s) begin
            seen_r <= seen_r | ~sel_r;
         end
      end
   end

   // Frame FSM next state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         COLLECT: begin
            if (seen_r == 4'hF) begin
               state_nxt_s = CHECK;
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         CHECK:   state_nxt_s = COLLECT;
         default: state_nxt_s = COLLECT;
      endcase
   end

   // Frame FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= COLLECT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame arithmetic; blank and bad slots hold value 0 so they never trip the range test
   always_comb begin
      hours_s     = ({3'b000, val_r[3]} * 7'd10) + {3'b000, val_r[2]};
      minutes_s   = ({2'b00, val_r[1]} * 6'd10) + {2'b00, val_r[0]};
      range_err_s = (val_r[3] > 4'd2) || (hours_s > 7'd23) || (val_r[1] > 4'd5);
   end

   // Frame outcome pulses and decoded time
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ore         <= 5'd0;
         minute      <= 6'd0;
         frame_valid <= 1'b0;
         frame_blank <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_blank <= 1'b0;
         frame_error <= 1'b0;
         if (state_r == CHECK) begin
            if ((|bad_r) || range_err_s) begin
               frame_error <= 1'b1;
            end else if (|blank_r) begin
               frame_blank <= 1'b1;
            end else begin
               frame_valid <= 1'b1;
               ore         <= hours_s[4:0];
               minute      <= minutes_s;
            end
         end
      end
   end

   // Stale counter next value, saturating
   always_comb begin
      if (frame_valid) begin
         stale_cnt_nxt_s = 16'd0;
      end else if (stale_cnt_r == 16'hFFFF) begin
         stale_cnt_nxt_s = stale_cnt_r;
      end else begin
         stale_cnt_nxt_s = stale_cnt_r + 16'd1;
      end
   end

   // Stale counter and flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stale_cnt_r <= 16'd0;
         stale       <= 1'b0;
      end else begin
         stale_cnt_r <= stale_cnt_nxt_s;
         stale       <= (stale_cnt_nxt_s >= TIMEOUT_C);
      end
   end

endmodule
